spec_return_stack: RTL and testbench
====================================

# spec_return_stack

Parametrised, speculation-aware return address stack for the fetch-stage branch predictor. It pushes call return addresses and pops predicted return targets. On overflow it overwrites the oldest entry as a circular buffer instead of dropping the push. Every cycle it exports a checkpoint of its pointer state so the back end can restore it on a branch mispredict.

## Interface
- ADDR_W, 32, width of a stored return address
- DEPTH, 8, number of entries; power of two, >= 2
- PTR_W, $clog2(DEPTH), derived: top-of-stack pointer width
- CNT_W, $clog2(DEPTH)+1, derived: occupancy count width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- push_i  in  1  call predicted this cycle
- pop_i  in  1  return predicted this cycle
- push_addr_i  in  ADDR_W  return address to push
- top_o  out  ADDR_W  current top entry, combinational from registered state
- valid_o  out  1  occupancy count != 0
- full_o  out  1  occupancy count == DEPTH
- ovf_o  out  1  registered one-cycle pulse: previous cycle's push overwrote the oldest entry
- ckpt_o  out  PTR_W+CNT_W  {ptr, count} of current (pre-update) state
- restore_i  in  1  load pointer state from restore_ckpt_i
- restore_ckpt_i  in  PTR_W+CNT_W  checkpoint previously taken from ckpt_o

## Operation
- State: mem[DEPTH] of ADDR_W, ptr (PTR_W), count (0..DEPTH), ovf register.
- top_o = mem[ptr] in all cases; consumers gate it with valid_o.
- Command priority: restore_i, then push_i & pop_i, then push_i, then pop_i.
- Restore: {ptr, count} <= restore_ckpt_i. mem is unchanged (see Configuration). push_i and pop_i are ignored that cycle. ovf <= 0.
- Push only: ptr <= ptr+1 mod DEPTH; mem[ptr+1] <= push_addr_i.
  - count < DEPTH: count+1, ovf <= 0.
  - count == DEPTH: count unchanged, oldest entry overwritten, ovf <= 1.
- Pop only:
  - count > 0: ptr <= ptr-1 mod DEPTH; count-1. The popped entry is not cleared.
  - count == 0: no state change (underflow ignored).
  - ovf <= 0.
- Push and pop together (return immediately followed by call):
  - count > 0: replace top, mem[ptr] <= push_addr_i; ptr and count unchanged.
  - count == 0: behaves as push only.
- Idle: ovf <= 0; all other state holds.
- Pointer arithmetic wraps modulo DEPTH (PTR_W bits). count saturates at DEPTH and floors at 0.

## Timing
- Reset (async assert, released synchronously by the SoC): ptr=0, count=0, all mem=0, ovf=0.
  - Resulting outputs: top_o=0, valid_o=0, full_o=0, ovf_o=0, ckpt_o=0.
- Reset mid-operation discards all entries immediately, with no clock edge required.
- Commands sampled at rising edge of clk; effect visible on top_o, valid_o, full_o and ckpt_o in the same cycle after that edge (1-cycle latency).
- ckpt_o reflects state before the current cycle's command. Front end stores it alongside each predicted branch.
- No handshake; every cycle accepts one command, never stalls.

## Configuration
- SPEC_RETURN_STACK_TOP_REPAIR_EN defined:
  - Adds ports ckpt_top_o (out, ADDR_W, = mem[ptr]) and restore_top_i (in, ADDR_W).
  - On restore, mem[restore ptr] <= restore_top_i in addition to the pointer restore. This repairs the top entry corrupted by a wrong-path push.
- Macro not defined: these ports are absent. Restore recovers pointer and count only; entries overwritten on the wrong path stay corrupted.

## Test plan
- Reset, push 0x100, 0x200, 0x300 -> top_o=0x300, valid_o=1; three pops -> top_o 0x200, 0x100, then valid_o=0; fourth pop -> no change.
- DEPTH=8: push 0x10..0x90 (9 pushes) -> ovf_o=1 for one cycle after the 9th, full_o=1; 8 pops return 0x90 down to 0x20, then valid_o=0.
- Push 0xA0, then push_i & pop_i with 0xB0 -> top_o=0xB0, count still 1; same command on empty stack -> top_o=0xB0, count 1.
- Push 0x1, 0x2, capture ckpt_o, pop, push 0x7, restore_i with captured value.
  - Pointer and count return to their captured values (count=2).
  - With macro and restore_top_i=0x2: top_o=0x2.
  - Without macro: top_o=0x7 (wrong-path push left in place).
- restore_i together with push_i and pop_i -> only the restore takes effect.
- Assert reset asynchronously between clock edges with 5 entries -> valid_o=0 and top_o=0 before the next edge.

Source files
------------

// File: rtl/spec_return_stack_if.sv
// Command/response bundle of the speculative return address stack.
//
// Purpose : groups the front-end command signals (push/pop/restore) and the
//           stack outputs (top entry, occupancy flags, checkpoint) into one
//           interface. clk and reset stay plain ports on the design.
// Modports: master - predictor front end (drives commands, reads outputs)
//           slave  - the stack itself
// Optional: SPEC_RETURN_STACK_TOP_REPAIR_EN adds ckpt_top_o / restore_top_i.
interface spec_return_stack_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   push_i;
  logic                   pop_i;
  logic [ADDR_W-1:0]      push_addr_i;
  logic                   restore_i;
  logic [PTR_W+CNT_W-1:0] restore_ckpt_i;
  logic [ADDR_W-1:0]      top_o;
  logic                   valid_o;
  logic                   full_o;
  logic                   ovf_o;
  logic [PTR_W+CNT_W-1:0] ckpt_o;
`ifdef SPEC_RETURN_STACK_TOP_REPAIR_EN
  logic [ADDR_W-1:0]      ckpt_top_o;
  logic [ADDR_W-1:0]      restore_top_i;
`endif

  modport master (
    output push_i, pop_i, push_addr_i, restore_i, restore_ckpt_i,
`ifdef SPEC_RETURN_STACK_TOP_REPAIR_EN
    output restore_top_i,
    input  ckpt_top_o,
`endif
    input  top_o, valid_o, full_o, ovf_o, ckpt_o
  );

  modport slave (
    input  push_i, pop_i, push_addr_i, restore_i, restore_ckpt_i,
`ifdef SPEC_RETURN_STACK_TOP_REPAIR_EN
    input  restore_top_i,
    output ckpt_top_o,
`endif
    output top_o, valid_o, full_o, ovf_o, ckpt_o
  );
endinterface

// File: rtl/spec_return_stack.sv
// Speculation-aware return address stack for the fetch-stage predictor.
//
// Purpose : pushes call return addresses, pops predicted return targets.
//           On overflow the oldest entry is overwritten (circular buffer).
//           Exports {ptr, count} every cycle so the back end can roll the
//           pointer state back after a mispredict.
// Ports   : clk   - clock, all state updates on the rising edge
//           reset - asynchronous, active-high; clears pointers and entries
//           rs    - spec_return_stack_if.slave (commands, top, flags, ckpt)
// Optional: define SPEC_RETURN_STACK_TOP_REPAIR_EN to also checkpoint and
//           restore the top entry (ckpt_top_o / restore_top_i), repairing
//           a top slot clobbered by a wrong-path push.
module spec_return_stack #(
  parameter  int ADDR_W = 32,
  parameter  int DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input logic               clk,
  input logic               reset,
  spec_return_stack_if.slave rs
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf;

  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic [PTR_W-1:0]  restore_ptr;
  logic [CNT_W-1:0]  restore_count;
  logic              is_empty;
  logic              is_full;

  // DEPTH is a power of two, so PTR_W-bit wraparound is the modulo.
  assign ptr_inc  = ptr + PTR_W'(1);
  assign ptr_dec  = ptr - PTR_W'(1);
  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_W'(DEPTH));

  assign {restore_ptr, restore_count} = rs.restore_ckpt_i;

  assign rs.top_o   = mem[ptr];
  assign rs.valid_o = !is_empty;
  assign rs.full_o  = is_full;
  assign rs.ovf_o   = ovf;
  assign rs.ckpt_o  = {ptr, count};
`ifdef SPEC_RETURN_STACK_TOP_REPAIR_EN
  assign rs.ckpt_top_o = mem[ptr];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ovf <= 1'b0;
      if (rs.restore_i) begin
        // Restore wins over any same-cycle push/pop.
        ptr   <= restore_ptr;
        count <= restore_count;
`ifdef SPEC_RETURN_STACK_TOP_REPAIR_EN
        mem[restore_ptr] <= rs.restore_top_i;
`endif
      end else if (rs.push_i && rs.pop_i && !is_empty) begin
        // Return then call: the new return address replaces the top.
        mem[ptr] <= rs.push_addr_i;
      end else if (rs.push_i) begin
        // Also covers push+pop on an empty stack.
        ptr          <= ptr_inc;
        mem[ptr_inc] <= rs.push_addr_i;
        if (is_full) ovf   <= 1'b1;
        else         count <= count + CNT_W'(1);
      end else if (rs.pop_i && !is_empty) begin
        // Popped entry is left in place; underflow is ignored.
        ptr   <= ptr_dec;
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spec_return_stack.sv
// Self-checking bench for spec_return_stack (DEPTH=8, ADDR_W=32).
module tb_spec_return_stack;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  spec_return_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) rs_if ();

  spec_return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .rs    (rs_if.slave)
  );

  typedef struct {
    logic        push;
    logic        pop;
    logic [31:0] addr;
    logic [31:0] e_top;
    logic        e_valid;
    logic        e_full;
    logic        e_ovf;
    logic [6:0]  e_ckpt;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(logic push, logic pop, logic [31:0] addr,
                              logic [31:0] e_top, logic e_valid,
                              int e_ptr, int e_cnt);
    vec_t v;
    v.push = push; v.pop = pop; v.addr = addr;
    v.e_top = e_top; v.e_valid = e_valid;
    v.e_full = (e_cnt == DEPTH); v.e_ovf = 1'b0;
    v.e_ckpt = {3'(e_ptr), 4'(e_cnt)};
    return v;
  endfunction

  function automatic logic [6:0] ck(int p, int c);
    return {3'(p), 4'(c)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [31:0] e_top, input logic do_top,
                            input logic e_valid, input logic e_full, input logic e_ovf,
                            input logic [6:0] e_ckpt);
    if (do_top) chk({name, "_top"}, rs_if.top_o, e_top);
    chk({name, "_valid"}, 32'(rs_if.valid_o), 32'(e_valid));
    chk({name, "_full"},  32'(rs_if.full_o),  32'(e_full));
    chk({name, "_ovf"},   32'(rs_if.ovf_o),   32'(e_ovf));
    chk({name, "_ckpt"},  32'(rs_if.ckpt_o),  32'(e_ckpt));
  endtask

  // Drive one command for one clock edge, then return to idle 1 time unit after it.
  task automatic apply(input logic push, input logic pop, input logic restore,
                       input logic [31:0] addr, input logic [6:0] rckpt,
                       input logic [31:0] rtop);
    rs_if.push_i         = push;
    rs_if.pop_i          = pop;
    rs_if.restore_i      = restore;
    rs_if.push_addr_i    = addr;
    rs_if.restore_ckpt_i = rckpt;
`ifdef SPEC_RETURN_STACK_TOP_REPAIR_EN
    rs_if.restore_top_i  = rtop;
`endif
    @(posedge clk);
    #1;
    rs_if.push_i    = 1'b0;
    rs_if.pop_i     = 1'b0;
    rs_if.restore_i = 1'b0;
  endtask

  // Asynchronous assert between edges, synchronous-style release.
  task automatic do_reset();
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Reference model: a bounded LIFO; the oldest element falls off when full.
  logic [31:0] q[$];
  int          pos;

  initial begin
    logic [6:0]  saved;
    logic [31:0] e_top;
    logic        push, pop;
    logic [31:0] addr;
    logic        e_ovf;

    rs_if.push_i = 1'b0; rs_if.pop_i = 1'b0; rs_if.restore_i = 1'b0;
    rs_if.push_addr_i = '0; rs_if.restore_ckpt_i = '0;
`ifdef SPEC_RETURN_STACK_TOP_REPAIR_EN
    rs_if.restore_top_i = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h0);
    reset = 1'b0;

    // Basic LIFO order, underflow, push+pop replacement (nonempty and empty).
    tbl[0]  = mk(1, 0, 32'h100, 32'h100, 1, 1, 1);
    tbl[1]  = mk(1, 0, 32'h200, 32'h200, 1, 2, 2);
    tbl[2]  = mk(1, 0, 32'h300, 32'h300, 1, 3, 3);
    tbl[3]  = mk(0, 1, 32'h0,   32'h200, 1, 2, 2);
    tbl[4]  = mk(0, 1, 32'h0,   32'h100, 1, 1, 1);
    tbl[5]  = mk(0, 1, 32'h0,   32'h0,   0, 0, 0);
    tbl[6]  = mk(0, 1, 32'h0,   32'h0,   0, 0, 0);
    tbl[7]  = mk(1, 0, 32'hA0,  32'hA0,  1, 1, 1);
    tbl[8]  = mk(1, 1, 32'hB0,  32'hB0,  1, 1, 1);
    tbl[9]  = mk(0, 1, 32'h0,   32'h0,   0, 0, 0);
    tbl[10] = mk(1, 1, 32'hB0,  32'hB0,  1, 1, 1);
    tbl[11] = mk(0, 1, 32'h0,   32'hB0,  0, 0, 0);
    tbl[11].e_top = 32'h0;  // mem[0] never written since reset
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].push, tbl[i].pop, 1'b0, tbl[i].addr, 7'h0, 32'h0);
      check_outs($sformatf("tbl%0d", i), tbl[i].e_top, 1'b1, tbl[i].e_valid,
                 tbl[i].e_full, tbl[i].e_ovf, tbl[i].e_ckpt);
    end

    // Overflow: 9 pushes into DEPTH=8, then 8 pops.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      apply(1'b1, 1'b0, 1'b0, 32'(16 * k), 7'h0, 32'h0);
      check_outs($sformatf("ovf_push%0d", k), 32'(16 * k), 1'b1, 1'b1,
                 k >= 8, k == 9, ck(k % 8, (k > 8) ? 8 : k));
    end
    apply(1'b0, 1'b0, 1'b0, 32'h0, 7'h0, 32'h0);
    check_outs("ovf_idle", 32'h90, 1'b1, 1'b1, 1'b1, 1'b0, ck(1, 8));
    for (int k = 1; k <= 8; k++) begin
      e_top = (k < 8) ? 32'(16 * (9 - k)) : 32'h90;
      apply(1'b0, 1'b1, 1'b0, 32'h0, 7'h0, 32'h0);
      check_outs($sformatf("ovf_pop%0d", k), e_top, 1'b1, k < 8, 1'b0, 1'b0,
                 ck((9 - k) % 8, 8 - k));
    end

    // Checkpoint / restore after a wrong-path pop+push.
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 32'h1, 7'h0, 32'h0);
    apply(1'b1, 1'b0, 1'b0, 32'h2, 7'h0, 32'h0);
    saved = rs_if.ckpt_o;
    chk("ckpt_capture", 32'(saved), 32'(ck(2, 2)));
    apply(1'b0, 1'b1, 1'b0, 32'h0, 7'h0, 32'h0);
    apply(1'b1, 1'b0, 1'b0, 32'h7, 7'h0, 32'h0);
    apply(1'b0, 1'b0, 1'b1, 32'h0, ck(2, 2), 32'h2);
`ifdef SPEC_RETURN_STACK_TOP_REPAIR_EN
    check_outs("restore", 32'h2, 1'b1, 1'b1, 1'b0, 1'b0, ck(2, 2));
`else
    check_outs("restore", 32'h7, 1'b1, 1'b1, 1'b0, 1'b0, ck(2, 2));
`endif
    // Restore with push and pop asserted: only the restore applies.
    apply(1'b1, 1'b1, 1'b1, 32'h55, ck(1, 1), 32'h1);
    check_outs("restore_prio", 32'h1, 1'b1, 1'b1, 1'b0, 1'b0, ck(1, 1));

    // Restore clears a pending overflow pulse.
    do_reset();
    for (int k = 1; k <= 9; k++) apply(1'b1, 1'b0, 1'b0, 32'(k), 7'h0, 32'h0);
    chk("ovf_before_restore", 32'(rs_if.ovf_o), 32'h1);
    apply(1'b1, 1'b0, 1'b1, 32'hEE, ck(3, 3), 32'h3);
    check_outs("restore_ovf", 32'h3, 1'b1, 1'b1, 1'b0, 1'b0, ck(3, 3));

    // Asynchronous reset mid-operation with 5 entries.
    do_reset();
    for (int k = 1; k <= 5; k++) apply(1'b1, 1'b0, 1'b0, 32'(k + 32'h40), 7'h0, 32'h0);
    chk("pre_areset_valid", 32'(rs_if.valid_o), 32'h1);
    #1 reset = 1'b1;
    #1;
    check_outs("areset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomized push/pop against the reference model.
    q.delete();
    pos = 0;
    for (int n = 0; n < 600; n++) begin
      push = ($urandom_range(0, 99) < 55);
      pop  = ($urandom_range(0, 99) < 45);
      addr = $urandom;
      apply(push, pop, 1'b0, addr, 7'h0, 32'h0);
      e_ovf = 1'b0;
      if (push && pop && q.size() > 0) begin
        q[q.size() - 1] = addr;
      end else if (push) begin
        if (q.size() == DEPTH) begin
          void'(q.pop_front());
          e_ovf = 1'b1;
        end
        q.push_back(addr);
        pos++;
      end else if (pop && q.size() > 0) begin
        void'(q.pop_back());
        pos--;
      end
      check_outs($sformatf("rnd%0d", n), (q.size() > 0) ? q[q.size() - 1] : 32'h0,
                 q.size() > 0, q.size() > 0, q.size() == DEPTH, e_ovf,
                 ck(pos % DEPTH, q.size()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
